// File: rtl/rapid_pkg.sv
// rapid_pkg: shared types, mul/div op codes and defaults for the execute stage
package rapid_pkg;

  typedef enum logic [1:0] {IDLE, RESULT, MD_BUSY} ex_pipe_state_t;

  typedef struct packed {
    logic       alu_imm;
    logic       alu_reg;
    logic       cond_branch;
    logic       uncond_branch;
    logic       load_upper_imm;
    logic       mem;
    logic       muldiv;
    logic [2:0] fcs_opcode;
    logic       iop;
  } control_s;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  function automatic control_s control_s_default();
    return '0;
  endfunction

endpackage

// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative shift-add multiplier / restoring divider, built only with RAPID_EX_MULDIV_EN
`ifdef RAPID_EX_MULDIV_EN
module md_iter_unit
  import rapid_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_STEPS = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int K  = XLEN / MD_STEPS;
  localparam int CW = $clog2(K + 1);

  logic            busy, neg_q, neg_r, b_zero, sa, sb;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] p, p_n, full;
  logic [XLEN-1:0] bm, a_r;
  logic [2:0]      op_r;

  assign sa   = (op == MULH || op == MULHSU || op == DIV || op == REM) && a[XLEN-1];
  assign sb   = (op == MULH || op == DIV || op == REM) && b[XLEN-1];
  assign done = busy && cnt == CW'(K);

  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] x, input logic [XLEN-1:0] m);
    logic [XLEN:0] t;
    t = {1'b0, x[2*XLEN-1:XLEN]} + (x[0] ? {1'b0, m} : '0);
    return {t, x[XLEN-1:1]};
  endfunction

  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] x, input logic [XLEN-1:0] m);
    logic [XLEN:0] r;
    logic ge;
    r  = x[2*XLEN-1:XLEN-1];
    ge = r >= {1'b0, m};
    r  = ge ? r - {1'b0, m} : r;
    return {r[XLEN-1:0], x[XLEN-2:0], ge};
  endfunction

  // MD_STEPS iterations of the magnitude multiply/divide per clock
  always_comb begin
    p_n = p;
    for (int i = 0; i < MD_STEPS; i++) p_n = op_r[2] ? div_step(p_n, bm) : mul_step(p_n, bm);
  end

  // operands are reduced to magnitudes up front; signs are reapplied on the result
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      p      <= '0;
      bm     <= '0;
      a_r    <= '0;
      op_r   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else if (abort) busy <= 1'b0;
    else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      p      <= {XLEN'(0), sa ? -a : a};
      bm     <= sb ? -b : b;
      a_r    <= a;
      op_r   <= op;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      b_zero <= b == '0;
    end else if (done) busy <= 1'b0;
    else if (busy) begin
      p   <= p_n;
      cnt <= cnt + 1'b1;
    end

  // sign fix-up and the divide-by-zero results
  always_comb begin
    full   = neg_q ? -p : p;
    result = !op_r[2] ? (op_r[1:0] == 2'd0 ? full[XLEN-1:0] : full[2*XLEN-1:XLEN]) :
             b_zero ? (op_r[1] ? a_r : '1) :
             op_r[1] ? (neg_r ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN]) :
             (neg_q ? -p[XLEN-1:0] : p[XLEN-1:0]);
  end
endmodule
`endif

// File: rtl/execute_pipe_stage.sv
// execute_pipe_stage: handshaked RV32I/M execute stage; RAPID_EX_MULDIV_EN enables the iterative mul/div unit
module execute_pipe_stage
  import rapid_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_STEP  = 4,
  parameter int MD_STEPS = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  control_s        i_control,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_valid,
  input  logic            i_ready,
  output control_s        o_control,
  output logic [XLEN-1:0] o_rd_output,
  output logic [XLEN-1:0] o_rs2,
  output logic [XLEN-1:0] o_pc_ext,
  output logic            o_pc_load,
  output logic            o_illegal,
  output ex_pipe_state_t  o_state
);
  localparam int SW = $clog2(XLEN);
`ifdef RAPID_EX_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic            accept, md_done, pc_load_n, illegal_n, taken;
  logic [XLEN-1:0] md_result, rd_n, pc_ext_n, step;

  assign o_ready   = !i_flush && (o_state == IDLE || (o_state == RESULT && i_ready));
  assign accept    = i_valid && o_ready;
  assign step      = XLEN'(PC_STEP);
  assign illegal_n = i_control.muldiv && !MD_EN;

`ifdef RAPID_EX_MULDIV_EN
  md_iter_unit #(.XLEN(XLEN), .MD_STEPS(MD_STEPS)) u_md (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .start  (accept && i_control.muldiv),
    .abort  (i_flush),
    .op     (i_control.fcs_opcode),
    .a      (i_rs1),
    .b      (i_rs2),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f, input logic iop, sub,
                                          input logic [XLEN-1:0] a, b);
    logic [SW-1:0] sh;
    logic signed [XLEN-1:0] s;
    sh = b[SW-1:0];
    s  = $signed(a) >>> sh;
    case (f)
      3'd0:    alu = sub ? a - b : a + b;
      3'd1:    alu = a << sh;
      3'd2:    alu = XLEN'($signed(a) < $signed(b));
      3'd3:    alu = XLEN'(a < b);
      3'd4:    alu = a ^ b;
      3'd5:    alu = iop ? s : a >> sh;
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // single-cycle result, redirect target and branch decision for the incoming op
  always_comb begin
    taken = i_control.fcs_opcode[2] ?
            ((i_control.fcs_opcode[1] ? i_rs1 < i_rs2 : $signed(i_rs1) < $signed(i_rs2)) ^ i_control.fcs_opcode[0]) :
            ((i_rs1 == i_rs2) ^ i_control.fcs_opcode[0]);
    rd_n      = '0;
    pc_ext_n  = i_pc + step;
    pc_load_n = 1'b0;
    if (i_control.muldiv) rd_n = '0;
    else if (i_control.alu_imm || i_control.alu_reg)
      rd_n = alu(i_control.fcs_opcode, i_control.iop, i_control.iop && i_control.alu_reg,
                 i_rs1, i_control.alu_imm ? i_imm : i_rs2);
    else if (i_control.cond_branch) begin
      pc_load_n = taken;
      pc_ext_n  = taken ? i_pc + i_imm : i_pc + step;
    end else if (i_control.uncond_branch) begin
      rd_n      = i_pc + step;
      pc_load_n = 1'b1;
      pc_ext_n  = i_control.iop ? (i_rs1 + i_imm) & ~XLEN'(1) : i_pc + i_imm;
    end else if (i_control.load_upper_imm) rd_n = (i_control.iop ? i_pc : '0) + (i_imm << 12);
    else if (i_control.mem) rd_n = i_rs1 + i_imm;
  end

  // stage FSM with registered outputs; flush wins over every transition
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      o_state     <= IDLE;
      o_valid     <= 1'b0;
      o_pc_load   <= 1'b0;
      o_illegal   <= 1'b0;
      o_rd_output <= '0;
      o_rs2       <= '0;
      o_pc_ext    <= '0;
      o_control   <= control_s_default();
    end else if (i_flush) begin
      o_state <= IDLE;
      o_valid <= 1'b0;
    end else if (accept) begin
      o_state     <= (MD_EN && i_control.muldiv) ? MD_BUSY : RESULT;
      o_valid     <= !(MD_EN && i_control.muldiv);
      o_control   <= i_control;
      o_rd_output <= rd_n;
      o_rs2       <= i_rs2;
      o_pc_ext    <= pc_ext_n;
      o_pc_load   <= pc_load_n;
      o_illegal   <= illegal_n;
    end else if (o_state == RESULT && i_ready) begin
      o_state <= IDLE;
      o_valid <= 1'b0;
    end else if (o_state == MD_BUSY && md_done) begin
      o_state     <= RESULT;
      o_valid     <= 1'b1;
      o_rd_output <= md_result;
    end
endmodule
